// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem handshake, held instruction, retire count
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        PCSrc,
    input  logic [31:0] PCTarget,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] instret,
    output logic        misalign
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instret_q, instret_d;
    logic        misalign_q, misalign_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            instret_q  <= 32'd0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instret_q  <= instret_d;
            misalign_q <= misalign_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instret_d  = instret_q;
        misalign_d = misalign_q;
        case (state_q)
            S_FETCH: begin
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!stall) begin
                    instret_d = instret_q + 32'd1;
                    instr_d   = NOP_INSTR;
                    state_d   = S_FETCH;
                    if (!PCSrc) begin
                        pc_d = pc_q + 32'd4;
                    end else begin
                        pc_d = PCTarget;
                        // A misaligned target parks the unit until reset.
                        if (PCTarget[1:0] != 2'b00) begin
                            misalign_d = 1'b1;
                            state_d    = S_HALT;
                        end
                    end
                end
            end
            S_HALT: begin
                instr_d = NOP_INSTR;
            end
            default: begin
                state_d = S_FETCH;
                instr_d = NOP_INSTR;
            end
        endcase
    end

    assign imem_req    = (state_q == S_FETCH);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == S_EXEC);
    assign instr       = instr_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign instret     = instret_q;
    assign misalign    = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - table-driven bench for fetch_unit
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, imem_req, imem_ready, stall, pcsrc, instr_valid, misalign;
    logic [31:0] imem_addr, imem_rdata, pctarget, instr, pc, pc_plus4, instret;

    logic        rst2, req2, ready2, stall2, pcsrc2, valid2, mis2;
    logic [31:0] addr2, rdata2, target2, instr2, pc2, pcp4_2, instret2;

    fetch_unit dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready), .stall(stall),
        .PCSrc(pcsrc), .PCTarget(pctarget), .instr(instr), .instr_valid(instr_valid),
        .pc(pc), .pc_plus4(pc_plus4), .instret(instret), .misalign(misalign)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst2), .imem_req(req2), .imem_addr(addr2),
        .imem_rdata(rdata2), .imem_ready(ready2), .stall(stall2),
        .PCSrc(pcsrc2), .PCTarget(target2), .instr(instr2), .instr_valid(valid2),
        .pc(pc2), .pc_plus4(pcp4_2), .instret(instret2), .misalign(mis2)
    );

    typedef struct {
        logic        rst;
        logic        rdy;
        logic [31:0] rdata;
        logic        stall;
        logic        pcsrc;
        logic [31:0] tgt;
        logic        e_req;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_valid;
        logic [31:0] e_instret;
        logic        e_mis;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic add(input logic r, input logic rdy, input logic [31:0] rdata,
                       input logic st, input logic ps, input logic [31:0] tgt,
                       input logic e_req, input logic [31:0] e_pc, input logic [31:0] e_instr,
                       input logic e_valid, input logic [31:0] e_instret, input logic e_mis);
        vec_t v;
        v.rst = r; v.rdy = rdy; v.rdata = rdata; v.stall = st; v.pcsrc = ps; v.tgt = tgt;
        v.e_req = e_req; v.e_pc = e_pc; v.e_instr = e_instr; v.e_valid = e_valid;
        v.e_instret = e_instret; v.e_mis = e_mis;
        vecs.push_back(v);
    endtask

    task automatic apply(input int idx, input vec_t v);
        @(negedge clk);
        rst = v.rst; imem_ready = v.rdy; imem_rdata = v.rdata;
        stall = v.stall; pcsrc = v.pcsrc; pctarget = v.tgt;
        @(posedge clk);
        #1;
        n_vec++;
        if (imem_req !== v.e_req || imem_addr !== v.e_pc || pc !== v.e_pc ||
            pc_plus4 !== v.e_pc + 32'd4 || instr !== v.e_instr ||
            instr_valid !== v.e_valid || instret !== v.e_instret || misalign !== v.e_mis) begin
            n_err++;
            $display("FAIL vec%0d: got req=%b addr=%h pc=%h pc4=%h instr=%h valid=%b instret=%0d mis=%b; want req=%b pc=%h instr=%h valid=%b instret=%0d mis=%b",
                     idx, imem_req, imem_addr, pc, pc_plus4, instr, instr_valid, instret, misalign,
                     v.e_req, v.e_pc, v.e_instr, v.e_valid, v.e_instret, v.e_mis);
        end
    endtask

    task automatic check2(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    initial begin
        rst = 1'b1; imem_ready = 1'b0; imem_rdata = 32'd0; stall = 1'b0; pcsrc = 1'b0; pctarget = 32'd0;
        rst2 = 1'b1; ready2 = 1'b0; rdata2 = 32'd0; stall2 = 1'b0; pcsrc2 = 1'b0; target2 = 32'd0;

        // reset, then four zero-wait instructions
        add(1, 0, 32'h0,     0, 0, 32'h0,   1, 32'h00, NOP, 0, 0, 0);
        add(0, 1, NOP,       1, 0, 32'h0,   0, 32'h00, NOP, 1, 0, 0);
        add(0, 0, 32'h0,     0, 0, 32'h0,   1, 32'h04, NOP, 0, 1, 0);
        add(0, 1, NOP,       0, 0, 32'h0,   0, 32'h04, NOP, 1, 1, 0);
        add(0, 0, 32'h0,     0, 0, 32'h0,   1, 32'h08, NOP, 0, 2, 0);
        add(0, 1, NOP,       0, 0, 32'h0,   0, 32'h08, NOP, 1, 2, 0);
        add(0, 0, 32'h0,     0, 0, 32'h0,   1, 32'h0C, NOP, 0, 3, 0);
        add(0, 1, NOP,       0, 0, 32'h0,   0, 32'h0C, NOP, 1, 3, 0);
        add(0, 0, 32'h0,     0, 0, 32'h0,   1, 32'h10, NOP, 0, 4, 0);
        // three wait cycles at 0x10, PCSrc/stall in FETCH ignored
        add(0, 0, 32'hBAD,   1, 1, 32'h80,  1, 32'h10, NOP, 0, 4, 0);
        add(0, 0, 32'hBAD,   0, 1, 32'h80,  1, 32'h10, NOP, 0, 4, 0);
        add(0, 0, 32'hBAD,   0, 1, 32'h80,  1, 32'h10, NOP, 0, 4, 0);
        add(0, 1, 32'h00500093, 0, 0, 32'h0, 0, 32'h10, 32'h00500093, 1, 4, 0);
        // five stall cycles with stray ready and PCSrc
        for (int i = 0; i < 5; i++)
            add(0, 1, 32'hDEADBEEF, 1, 1, 32'h80, 0, 32'h10, 32'h00500093, 1, 4, 0);
        add(0, 0, 32'h0,     0, 1, 32'h40,  1, 32'h40, NOP, 0, 5, 0);
        add(0, 1, 32'h11111111, 0, 0, 32'h0, 0, 32'h40, 32'h11111111, 1, 5, 0);
        // misaligned target halts
        add(0, 0, 32'h0,     0, 1, 32'h42,  0, 32'h42, NOP, 0, 6, 1);
        add(0, 1, 32'h33,    0, 1, 32'h80,  0, 32'h42, NOP, 0, 6, 1);
        add(0, 1, 32'h33,    0, 0, 32'h0,   0, 32'h42, NOP, 0, 6, 1);
        add(1, 1, 32'h44,    0, 0, 32'h0,   1, 32'h00, NOP, 0, 0, 0);
        // reset during a wait cycle with a response present
        add(0, 0, 32'h0,     0, 0, 32'h0,   1, 32'h00, NOP, 0, 0, 0);
        add(1, 1, 32'h22,    0, 0, 32'h0,   1, 32'h00, NOP, 0, 0, 0);
        add(0, 1, 32'h55,    0, 0, 32'h0,   0, 32'h00, 32'h55, 1, 0, 0);
        add(1, 0, 32'h0,     0, 0, 32'h0,   1, 32'h00, NOP, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

        // PC wrap on an instance reset to the top word
        @(negedge clk); rst2 = 1'b1;
        @(posedge clk); #1;
        check2("wrap_reset_pc", pc2, 32'hFFFF_FFFC);
        check2("wrap_reset_pc4", pcp4_2, 32'h0);
        check2("wrap_reset_req", {31'd0, req2}, 32'd1);
        @(negedge clk); rst2 = 1'b0; ready2 = 1'b1; rdata2 = 32'h00100093;
        @(posedge clk); #1;
        check2("wrap_exec_valid", {31'd0, valid2}, 32'd1);
        check2("wrap_exec_instr", instr2, 32'h00100093);
        @(negedge clk); ready2 = 1'b0;
        @(posedge clk); #1;
        check2("wrap_commit_pc", pc2, 32'h0);
        check2("wrap_commit_pc4", pcp4_2, 32'h4);
        check2("wrap_commit_instret", instret2, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the single-cycle RISC-V core. Holds the program counter and issues word reads to instruction memory over a ready/valid-style handshake with variable latency. Presents one instruction at a time to the decode/control path (opcode, funct3 and funct7 fields feed the controller directly). Takes the controller's branch/jump decision (PCSrc) plus the datapath's branch target to select the next PC.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction driven when no valid instruction is held (addi x0,x0,0).
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- imem_req  output  1  read request to instruction memory.
- imem_addr  output  32  word-aligned read address; equals pc.
- imem_rdata  input  32  read data; sampled only when imem_req && imem_ready.
- imem_ready  input  1  memory completes the read this cycle.
- stall  input  1  downstream not ready to retire the held instruction.
- PCSrc  input  1  take PCTarget at commit (branch taken or jump).
- PCTarget  input  32  branch/jump target computed by the datapath.
- instr  output  32  held instruction; NOP_INSTR when instr_valid=0.
- instr_valid  output  1  instr is a real fetched instruction.
- pc  output  32  address of instr / current fetch.
- pc_plus4  output  32  pc + 4, modulo 2^32 (combinational).
- instret  output  32  retired-instruction count, wraps at 2^32.
- misalign  output  1  sticky: a misaligned target was taken; unit halted.

## Operation
- States: FETCH, EXEC, HALT. Reset state FETCH.
- FETCH: imem_req=1, imem_addr=pc. On a cycle with imem_ready=1: instr<=imem_rdata, instr_valid<=1, go to EXEC. While imem_ready=0: stay, hold pc and imem_addr stable.
- EXEC: imem_req=0, instr_valid=1. If stall=1: hold everything. If stall=0 (commit): instret<=instret+1, instr<=NOP_INSTR, instr_valid<=0, and:
  - PCSrc=0: pc<=pc+4, go to FETCH.
  - PCSrc=1, PCTarget[1:0]==0: pc<=PCTarget, go to FETCH.
  - PCSrc=1, PCTarget[1:0]!=0: pc<=PCTarget, misalign<=1, go to HALT.
- HALT: imem_req=0, instr_valid=0, instr=NOP_INSTR; only rst exits.
- PCSrc/PCTarget are ignored outside an EXEC commit cycle. stall is ignored outside EXEC.
- pc+4 and instret wrap silently: pc 32'hFFFF_FFFC advances to 32'h0000_0000.
- imem_rdata is never sampled when imem_req=0; a stray imem_ready in EXEC/HALT has no effect.

## Timing
- Reset values (cycle after rst high): pc=RESET_PC, state=FETCH, imem_req=1 from that cycle, instr=NOP_INSTR, instr_valid=0, instret=0, misalign=0.
- rst dominates every other input; a response arriving in a reset cycle is discarded. Reset mid-FETCH abandons the outstanding read; the memory must tolerate the request being dropped.
- Zero-wait memory (imem_ready high in first request cycle): 2 cycles per instruction (FETCH, EXEC). N wait cycles add N.
- All outputs except pc_plus4 are registered or decoded purely from state; no combinational path from imem_ready, stall or PCSrc to any output.
- Next-PC update, instret increment and instr_valid deassertion occur on the same commit edge.

## Test plan
- Reset, zero-wait memory returning 32'h0000_0013 at every address, stall=0, PCSrc=0 -> imem_addr sequence 0,4,8,12 each FETCH; instret=4 after 8 cycles; instr_valid toggles 0,1,0,1.
- Memory with 3 wait cycles at addr 0 returning 32'h00500093 -> imem_addr held at 0 for 4 cycles; instr=32'h00500093, instr_valid=1 on the following cycle; instr=NOP_INSTR before that.
- In EXEC hold stall=1 for 5 cycles, then 0 -> instr, pc, instret unchanged for 5 cycles; single commit afterwards; imem_req stays 0 during stall.
- At pc=32'h10 commit with PCSrc=1, PCTarget=32'h40 -> next imem_addr=32'h40; PCSrc=1 asserted in FETCH ignored (pc stays).
- Commit with PCSrc=1, PCTarget=32'h42 -> misalign=1, pc=32'h42, imem_req=0 permanently; assert rst -> misalign=0, pc=RESET_PC, fetching resumes.
- RESET_PC=32'hFFFF_FFFC, one commit with PCSrc=0 -> pc=32'h0; pc_plus4 at reset=32'h0. Assert rst during a wait cycle with imem_ready=1 -> instr_valid stays 0, imem_addr=RESET_PC.
